dmem_responder: RTL

//  Data-memory responder: the memory-side end of the core's load/store port. Accepts one request
//  per valid/ready handshake from the memory stage, applies funct3-sized byte-lane steering, and

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_lane_align.sv | 63 ++++++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 encodings and FSM states shared by the data-memory responder
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - funct3/address byte-lane steering for stores and load extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        reserved
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rword[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? rword[31:16] : rword[15:0];
    be         = 4'b0000;
    wdata_lane = 32'b0;
    rdata_ext  = 32'b0;
    misalign   = 1'b0;
    reserved   = 1'b0;
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        // addr_lo[0] is dropped, so a misaligned half truncates to its natural boundary
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{half_sel[15]}}, half_sel};
        misalign   = addr_lo[0];
      end
      F3_W: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
        misalign   = |addr_lo;
      end
      F3_BU: begin
        if (we) reserved = 1'b1;
        else    rdata_ext = {24'b0, byte_sel};
      end
      F3_HU: begin
        if (we) begin
          reserved = 1'b1;
        end else begin
          rdata_ext = {16'b0, half_sel};
          misalign  = addr_lo[0];
        end
      end
      default: reserved = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states; DMEM_MISALIGN_ERR_EN enables error responses
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [31:0] mem [DEPTH_WORDS];

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;

  logic          cur_we;
  logic [AW+1:0] cur_addr;
  logic [2:0]    cur_f3;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] cur_idx;

  logic [3:0]  be;
  logic [3:0]  be_eff;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;
  logic        misalign;
  logic        reserved;
  logic        bad;
  logic        err_val;
  logic [31:0] load_val;
  logic        commit;

  wire unused_addr_bits = ^req_addr[31:AW+2];

  // With no wait states the accept edge is also the commit edge, so the live request is used
  assign cur_we    = (state == IDLE) ? req_we                : we_q;
  assign cur_addr  = (state == IDLE) ? req_addr[AW+1:0]      : addr_q;
  assign cur_f3    = (state == IDLE) ? req_funct3            : f3_q;
  assign cur_wdata = (state == IDLE) ? req_wdata             : wdata_q;
  assign cur_idx   = cur_addr[AW+1:2];

  dmem_lane_align u_align (
    .we         (cur_we),
    .funct3     (cur_f3),
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .rword      (mem[cur_idx]),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign),
    .reserved   (reserved)
  );

`ifdef DMEM_MISALIGN_ERR_EN
  assign bad     = misalign | reserved;
  assign err_val = bad;
`else
  wire unused_misalign = misalign;
  assign bad     = reserved;
  assign err_val = 1'b0;
`endif

  assign be_eff   = bad ? 4'b0000 : be;
  assign load_val = (cur_we || bad) ? 32'b0 : rdata_ext;
  assign commit   = (WAIT_CYCLES == 0) ? (state == IDLE && req_valid)
                                       : (state == WAIT && wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (commit && cur_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_eff[i]) mem[cur_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      f3_q      <= 3'b0;
      wdata_q   <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr[AW+1:0];
            f3_q      <= req_funct3;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= load_val;
              rsp_err   <= err_val;
            end else begin
              state    <= WAIT;
              wait_cnt <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_val;
            rsp_err   <= err_val;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
